// File: rtl/pcm_to_i2s.sv
// pcm_to_i2s: serialises 24-bit PCM sample pairs into a 64-BCK I2S frame
// (two 32-bit slots, MSB one BCK after the LRCK edge), with a one-pair holding register.
module pcm_to_i2s #(
    parameter int CLK_DIV     = 4,
    parameter int SAMPLE_BITS = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [SAMPLE_BITS-1:0] sample_left,
    input  logic [SAMPLE_BITS-1:0] sample_right,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    output logic                   BCK,
    output logic                   LRCK,
    output logic                   DATAOUT,
    output logic                   underrun
);
    logic [7:0] div;
    logic [5:0] bit_cnt, b_next;
    logic [4:0] p;
    logic hold_full, wrap, fall, load, accept, dout_next;
    logic [SAMPLE_BITS-1:0] hold_left, hold_right, word_left, word_right, word;

    assign wrap         = div == 8'(CLK_DIV - 1);
    assign fall         = wrap && BCK;
    assign b_next       = bit_cnt + 6'd1;
    assign load         = fall && b_next == 6'd0;
    assign accept       = sample_valid && sample_ready;
    assign sample_ready = ~hold_full;
    assign p            = b_next[4:0];
    assign word         = b_next[5] ? word_right : word_left;

    // slot positions 0 and 25..31 are padding; 1..24 carry the word MSB first
    always_comb begin
        dout_next = 1'b0;
        if (p >= 5'd1 && p <= 5'(SAMPLE_BITS))
            dout_next = word[5'(SAMPLE_BITS) - p];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div        <= '0;
            BCK        <= 1'b0;
            bit_cnt    <= 6'd63;
            LRCK       <= 1'b0;
            DATAOUT    <= 1'b0;
            underrun   <= 1'b0;
            hold_full  <= 1'b0;
            hold_left  <= '0;
            hold_right <= '0;
            word_left  <= '0;
            word_right <= '0;
        end else begin
            underrun <= 1'b0;
            div      <= wrap ? 8'd0 : div + 8'd1;
            BCK      <= wrap ? ~BCK : BCK;
            if (fall) begin
                bit_cnt <= b_next;
                LRCK    <= b_next[5];
                DATAOUT <= dout_next;
            end
            // an empty holding register at frame load plays silence and flags it
            if (load) begin
                word_left  <= hold_full ? hold_left : '0;
                word_right <= hold_full ? hold_right : '0;
                underrun   <= ~hold_full;
            end
            if (accept) begin
                hold_left  <= sample_left;
                hold_right <= sample_right;
            end
            hold_full <= accept ? 1'b1 : load ? 1'b0 : hold_full;
        end
    end
endmodule

// File: tb/tb_pcm_to_i2s.sv
// tb_pcm_to_i2s: directed checks of I2S framing, handshake, underrun and async reset
// for pcm_to_i2s with CLK_DIV=4 (BCK period 8 clocks, frame 512 clocks).
module tb_pcm_to_i2s;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] sample_left = '0, sample_right = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready, BCK, LRCK, DATAOUT, underrun;
    int checks = 0, failures = 0, ur_cnt = 0, acc_cnt = 0, acc0 = 0;

    pcm_to_i2s #(.CLK_DIV(4), .SAMPLE_BITS(24)) dut (
        .clock(clock),
        .reset(reset),
        .sample_left(sample_left),
        .sample_right(sample_right),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .BCK(BCK),
        .LRCK(LRCK),
        .DATAOUT(DATAOUT),
        .underrun(underrun)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (underrun) ur_cnt++;
    always @(posedge clock) if (!reset && sample_valid && sample_ready) acc_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic exp_bit(input logic [23:0] l, input logic [23:0] r, input int b);
        logic [23:0] w;
        int p;
        w = (b < 32) ? l : r;
        p = b % 32;
        return (p >= 1 && p <= 24) ? w[24 - p] : 1'b0;
    endfunction

    // entered just after a frame-load edge; checks each falling event b=0..nb
    task automatic frame(input logic [23:0] l, input logic [23:0] r, input int nb);
        for (int b = 0; b <= nb; b++) begin
            if (b > 0) step(8);
            check($sformatf("dout_b%0d", b), 32'(DATAOUT), 32'(exp_bit(l, r, b)));
            check($sformatf("lrck_b%0d", b), 32'(LRCK), 32'(b >= 32));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        #2 reset = 1'b1;
        sample_left  = 24'hA5A5A5;
        sample_right = 24'h5A5A5A;
        sample_valid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_bck", 32'(BCK), 0);
        check("rst_lrck", 32'(LRCK), 0);
        check("rst_dout", 32'(DATAOUT), 0);
        check("rst_ur", 32'(underrun), 0);
        check("rst_rdy", 32'(sample_ready), 1);
        @(negedge clock) reset = 1'b0;
        step(1);
        check("acc_rdy", 32'(sample_ready), 0);
        sample_valid = 1'b0;
        step(2);
        check("bck_e3", 32'(BCK), 0);
        step(1);
        check("bck_e4", 32'(BCK), 1);
        step(3);
        check("bck_e7", 32'(BCK), 1);
        step(1);
        check("bck_e8", 32'(BCK), 0);
        check("ur_e8", 32'(underrun), 0);
        check("rdy_e8", 32'(sample_ready), 1);
        frame(24'hA5A5A5, 24'h5A5A5A, 63);
        step(7);
        check("ur_frame0", 32'(ur_cnt), 0);
        step(1);
        check("ur_load1", 32'(underrun), 1);
        frame(24'h0, 24'h0, 63);
        step(7);
        check("ur_width", 32'(ur_cnt), 1);
        step(1);
        check("ur_load2", 32'(underrun), 1);
        sample_left  = 24'h7FFFFF;
        sample_right = 24'h800000;
        sample_valid = 1'b1;
        frame(24'h0, 24'h0, 63);
        step(7);
        check("ur_idle", 32'(ur_cnt), 2);
        step(1);
        check("ur_load3", 32'(underrun), 0);
        acc0 = acc_cnt;
        frame(24'h7FFFFF, 24'h800000, 63);
        step(8);
        check("ur_load4", 32'(underrun), 0);
        check("acc_per_frame", 32'(acc_cnt - acc0), 1);
        sample_valid = 1'b0;
        frame(24'h7FFFFF, 24'h800000, 63);
        step(7);
        check("ur_stream", 32'(ur_cnt), 2);
        sample_left  = 24'h123456;
        sample_right = 24'hABCDEF;
        sample_valid = 1'b1;
        step(1);
        check("ur_coincide", 32'(underrun), 1);
        check("rdy_coincide", 32'(sample_ready), 0);
        sample_valid = 1'b0;
        frame(24'h0, 24'h0, 63);
        step(7);
        check("ur_after_coin", 32'(ur_cnt), 3);
        step(1);
        check("ur_load_next", 32'(underrun), 0);
        check("rdy_load_next", 32'(sample_ready), 1);
        frame(24'h123456, 24'hABCDEF, 40);
        check("dout_b40_hand", 32'(DATAOUT), 1);
        sample_left  = 24'hFFFFFF;
        sample_right = 24'hFFFFFF;
        sample_valid = 1'b1;
        step(1);
        sample_valid = 1'b0;
        check("rdy_pending", 32'(sample_ready), 0);
        step(4);
        check("bck_pre_rst", 32'(BCK), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_bck", 32'(BCK), 0);
        check("arst_lrck", 32'(LRCK), 0);
        check("arst_dout", 32'(DATAOUT), 0);
        check("arst_ur", 32'(underrun), 0);
        check("arst_rdy", 32'(sample_ready), 1);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        step(3);
        check("rs_bck_e3", 32'(BCK), 0);
        step(1);
        check("rs_bck_e4", 32'(BCK), 1);
        step(4);
        check("rs_bck_e8", 32'(BCK), 0);
        check("rs_ur_e8", 32'(underrun), 1);
        check("rs_rdy_e8", 32'(sample_ready), 1);
        frame(24'h0, 24'h0, 33);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
